// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the pixel PLL lock supervisor.
package pll_sup_pkg;

    localparam int STATUS_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } sup_state_e;

    // Counter width: enough bits for the largest cycle count, plus one spare.
    function automatic int cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Multi-flop synchroniser that brings the raw PLL LOCK into the board clock domain.
module lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    // Shift the asynchronous input through the chain; cleared to "unlocked".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Pixel PLL lock supervisor: sequences PLL RESETB, qualifies LOCK and releases
// the downstream domain resets one stage at a time.
// Optional status counters are built when PLL_SUPERVISOR_STATUS_EN is defined.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int LOCK_STABLE    = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int NUM_STAGES     = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  reinit_req,
    output logic                  pll_resetb,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready
`ifdef PLL_SUPERVISOR_STATUS_EN
    ,
    output logic [STATUS_W-1:0]   lock_loss_cnt,
    output logic [STATUS_W-1:0]   timeout_cnt
`endif
);

    localparam int CNT_W = cnt_w(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE,
                                 STAGE_GAP * NUM_STAGES);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(STAGE_GAP * (NUM_STAGES - 1));

    sup_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  pllResetb_q;
    logic [NUM_STAGES-1:0] stageRstN_q;
    logic                  ready_q;

    logic lockS;
    logic lossEvent;
    logic reinitEvent;
    logic restart;
    logic timeoutEvent;

    lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .async_i (pll_locked),
        .sync_o  (lockS)
    );

    // Lock loss only matters once stages may be released; reinit is ignored
    // while the PLL is already being reset, and is never queued.
    assign lossEvent    = !lockS && ((state_q == RELEASE) || (state_q == RUN));
    assign reinitEvent  = reinit_req && (state_q != PLL_RST);
    assign restart      = lossEvent || reinitEvent;
    assign timeoutEvent = (state_q == WAIT_LOCK) && !lockS && (cnt_q == TO_LAST) && !reinit_req;

    // Main sequencer; every output is a register so nothing passes straight through.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pllResetb_q <= 1'b0;
            stageRstN_q <= '0;
            ready_q     <= 1'b0;
        end else if (restart) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pllResetb_q <= 1'b0;
            stageRstN_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q     <= WAIT_LOCK;
                        cnt_q       <= '0;
                        pllResetb_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lockS) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (timeoutEvent) begin
                        state_q     <= PLL_RST;
                        cnt_q       <= '0;
                        pllResetb_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lockS) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q        <= RELEASE;
                        cnt_q          <= '0;
                        stageRstN_q[0] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == REL_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        for (int k = 1; k < NUM_STAGES; k++) begin
                            if (cnt_q == CNT_W'(STAGE_GAP * k - 1)) begin
                                stageRstN_q[k] <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= PLL_RST;
                    cnt_q       <= '0;
                    pllResetb_q <= 1'b0;
                    stageRstN_q <= '0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_resetb  = pllResetb_q;
    assign stage_rst_n = stageRstN_q;
    assign ready       = ready_q;

`ifdef PLL_SUPERVISOR_STATUS_EN
    logic [STATUS_W-1:0] lockLossCnt_q;
    logic [STATUS_W-1:0] timeoutCnt_q;

    // Saturating event counters; only a board reset clears them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lockLossCnt_q <= '0;
            timeoutCnt_q  <= '0;
        end else begin
            if (lossEvent && (lockLossCnt_q != '1)) begin
                lockLossCnt_q <= lockLossCnt_q + 1'b1;
            end
            if (timeoutEvent && (timeoutCnt_q != '1)) begin
                timeoutCnt_q <= timeoutCnt_q + 1'b1;
            end
        end
    end

    assign lock_loss_cnt = lockLossCnt_q;
    assign timeout_cnt   = timeoutCnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed, table-driven bench for pll_lock_supervisor with small test parameters.
// Status counters are checked when PLL_SUPERVISOR_STATUS_EN is defined.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       reinit_req = 1'b0;
    logic       pll_resetb;
    logic [2:0] stage_rst_n;
    logic       ready;
`ifdef PLL_SUPERVISOR_STATUS_EN
    logic [STATUS_W-1:0] lock_loss_cnt;
    logic [STATUS_W-1:0] timeout_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         doReset;
        bit         locked;
        bit         reinit;
        bit         expResetb;
        logic [2:0] expStage;
        bit         expReady;
        int         expLoss;
        int         expTo;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .LOCK_STABLE    (8),
        .STAGE_GAP      (2),
        .NUM_STAGES     (3),
        .SYNC_STAGES    (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .reinit_req  (reinit_req),
        .pll_resetb  (pll_resetb),
        .stage_rst_n (stage_rst_n),
        .ready       (ready)
`ifdef PLL_SUPERVISOR_STATUS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
`endif
    );

    // Free-running board clock.
    always #5 clock = ~clock;

    function automatic void addRows(input int n, input bit rst, input bit l, input bit ri,
                                    input bit rb, input logic [2:0] st, input bit rd,
                                    input int lc, input int tc, input string tag);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.doReset   = rst && (i == 0);
            v.locked    = l;
            v.reinit    = ri;
            v.expResetb = rb;
            v.expStage  = st;
            v.expReady  = rd;
            v.expLoss   = lc;
            v.expTo     = tc;
            v.tag       = tag;
            vecs.push_back(v);
        end
    endfunction

    task automatic checkVal(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input bit rb, input logic [2:0] st,
                               input bit rd, input int lc, input int tc);
        checkVal({name, ".pll_resetb"}, int'(pll_resetb), int'(rb));
        checkVal({name, ".stage_rst_n"}, int'(stage_rst_n), int'(st));
        checkVal({name, ".ready"}, int'(ready), int'(rd));
`ifdef PLL_SUPERVISOR_STATUS_EN
        checkVal({name, ".lock_loss_cnt"}, int'(lock_loss_cnt), lc);
        checkVal({name, ".timeout_cnt"}, int'(timeout_cnt), tc);
`else
        if (lc < 0 || tc < 0) $display("[TB] note: negative status expectation in %s", name);
`endif
    endtask

    task automatic applyStimulus(input bit l, input bit ri);
        pll_locked = l;
        reinit_req = ri;
    endtask

    // Assert reset, check it takes effect without a clock edge, release on a negedge.
    task automatic doReset(input string name);
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        reinit_req = 1'b0;
        #1;
        checkOutput({name, ".reset"}, 1'b0, 3'b000, 1'b0, 0, 0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #2;

        // Scenarios 1, 4, 2: lock from cycle 10, drop in RUN, then lock stuck low.
        addRows(3,  1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 0, 0, "s1_pllrst");
        addRows(6,  0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s1_waitlock");
        addRows(10, 0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s1_stable");
        addRows(2,  0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 0, 0, "s1_stage0");
        addRows(2,  0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 0, 0, "s1_stage1");
        addRows(1,  0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 0, 0, "s1_stage2");
        addRows(6,  0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 0, 0, "s1_run");
        addRows(2,  0, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 0, 0, "s4_syncdelay");
        addRows(4,  0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1, 0, "s4_loss");
        addRows(32, 0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1, 0, "s2_wait1");
        addRows(4,  0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1, 1, "s2_rst1");
        addRows(32, 0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1, 1, "s2_wait2");
        addRows(4,  0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1, 2, "s2_rst2");
        addRows(2,  0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1, 2, "s2_wait3");

        // Scenario 3: one-cycle glitch at stable count 5 delays release to cycle 20.
        addRows(3,  1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 0, 0, "s3_pllrst");
        addRows(5,  0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s3_stable");
        addRows(1,  0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s3_glitch");
        addRows(10, 0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s3_restable");
        addRows(2,  0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 0, 0, "s3_stage0");
        addRows(1,  0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 0, 0, "s3_stage1");

        // Scenario 5: lock lost between stage 0 and stage 1 release.
        addRows(3,  1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 0, 0, "s5_pllrst");
        addRows(9,  0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s5_stable");
        addRows(2,  0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 0, 0, "s5_stage0");
        addRows(4,  0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1, 0, "s5_loss");
        addRows(1,  0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1, 0, "s5_waitlock");

        // Scenario 6: reinit in RUN restarts; reinit in PLL_RST is ignored.
        addRows(3,  1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 0, 0, "s6_pllrst");
        addRows(9,  0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s6_stable");
        addRows(2,  0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 0, 0, "s6_stage0");
        addRows(2,  0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 0, 0, "s6_stage1");
        addRows(1,  0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 0, 0, "s6_stage2");
        addRows(3,  0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 0, 0, "s6_run");
        addRows(1,  0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 0, 0, "s6_reinit");
        addRows(1,  0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 0, 0, "s6_pllrst2");
        addRows(1,  0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 0, 0, "s6_reinit_ignored");
        addRows(1,  0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 0, 0, "s6_pllrst3");
        addRows(9,  0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 0, 0, "s6_relock");
        addRows(1,  0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 0, 0, "s6_rerelease");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doReset) doReset(vecs[i].tag);
            applyStimulus(vecs[i].locked, vecs[i].reinit);
            @(posedge clock);
            @(negedge clock);
            checkOutput($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].expResetb,
                        vecs[i].expStage, vecs[i].expReady, vecs[i].expLoss, vecs[i].expTo);
        end

        // Reset asserted mid-RELEASE clears everything without waiting for a clock edge.
        doReset("s6_midrel");
        applyStimulus(1'b1, 1'b0);
        repeat (14) begin
            @(posedge clock);
            @(negedge clock);
        end
        checkOutput("s6_midrel.before", 1'b1, 3'b001, 1'b0, 0, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("s6_midrel.async", 1'b0, 3'b000, 1'b0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        pll_locked = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
